// File: rtl/alu_ex_stage_pkg.sv
// Shared ALU control codes and datapath defaults for the EX stage and the ALU control decoder.
package alu_ex_stage_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRLV = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

endpackage

// File: rtl/alu_ex_stage_alu_core.sv
// Combinational ALU: result and signed add/sub overflow from the ALU control code.
module alu_core
    import alu_ex_stage_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_bit;

    // Wrapping add/sub; overflow when operand signs allow it and the result sign departs from a.
    always_comb begin
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        slt_bit = $signed(op_a) < $signed(op_b);
    end

    // Result and overflow mux; undefined codes produce zero with no overflow.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_ctl)
            ALU_ADD: begin
                result   = sum;
                overflow = add_ovf;
            end
            ALU_SUB: begin
                result   = diff;
                overflow = sub_ovf;
            end
            ALU_AND:  result = op_a & op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_NOR:  result = ~(op_a | op_b);
            ALU_XOR:  result = op_a ^ op_b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_bit};
            ALU_SLL:  result = op_b << shamt;
            ALU_SRL:  result = op_b >> shamt;
            ALU_SRLV: result = op_b >> op_a[4:0];
            ALU_SRA:  result = $signed(op_b) >>> shamt;
            ALU_LUI:  result = WIDTH'({op_b[15:0], 16'h0000});
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// EX stage: ALU plus the EX/MEM pipeline register and a count of latched valid instructions.
module alu_ex_stage
    import alu_ex_stage_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEFAULT,
    parameter bit          TRAP_OVF = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    input  logic [4:0]       rd_in,
    input  logic             reg_write_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic [WIDTH-1:0] store_data_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             overflow,
    output logic [4:0]       rd_out,
    output logic             reg_write_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic [WIDTH-1:0] store_data_out,
    output logic [31:0]      ex_count
);

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic [4:0]       rd_q;
    logic             reg_write_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic [WIDTH-1:0] store_data_q;
    logic [31:0]      ex_count_q;

    logic             load_valid;
    logic             trap;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .alu_ctl (alu_ctl),
        .op_a    (op_a),
        .op_b    (op_b),
        .shamt   (shamt),
        .result  (alu_res),
        .overflow(alu_ovf)
    );

    // Qualify the incoming instruction: flush squashes it, an overflow trap kills its write.
    always_comb begin
        load_valid = in_valid && !flush;
        trap       = TRAP_OVF && alu_ovf;
    end

    // EX/MEM register: stall holds everything, flush clears valid and control, else all load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            store_data_q <= '0;
            ex_count_q   <= '0;
        end else if (!stall) begin
            result_q     <= alu_res;
            zero_q       <= (alu_res == '0);
            ovf_q        <= alu_ovf;
            rd_q         <= rd_in;
            store_data_q <= store_data_in;
            valid_q      <= load_valid;
            reg_write_q  <= load_valid && reg_write_in && !trap;
            mem_read_q   <= load_valid && mem_read_in;
            mem_write_q  <= load_valid && mem_write_in;
            if (load_valid) begin
                ex_count_q <= ex_count_q + 32'd1;
            end
        end
    end

    // Registered outputs straight from the pipeline register.
    always_comb begin
        out_valid      = valid_q;
        alu_result     = result_q;
        zero           = zero_q;
        overflow       = ovf_q;
        rd_out         = rd_q;
        reg_write_out  = reg_write_q;
        mem_read_out   = mem_read_q;
        mem_write_out  = mem_write_q;
        store_data_out = store_data_q;
        ex_count       = ex_count_q;
    end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage with a behavioural reference model checked every cycle.
module tb_alu_ex_stage;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  alu_ctl = 4'b0000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  shamt = '0;
    logic [4:0]  rd_in = '0;
    logic        reg_write_in = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [31:0] store_data_in = '0;

    logic        out_valid;
    logic [31:0] alu_result;
    logic        zero;
    logic        overflow;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [31:0] store_data_out;
    logic [31:0] ex_count;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic        m_valid = 0, m_zero = 0, m_ovf = 0, m_rw = 0, m_mr = 0, m_mw = 0;
    logic [31:0] m_result = 0, m_sd = 0, m_count = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] count_adj = 0;

    alu_ex_stage #(
        .WIDTH   (32),
        .TRAP_OVF(1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .alu_ctl       (alu_ctl),
        .op_a          (op_a),
        .op_b          (op_b),
        .shamt         (shamt),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .store_data_in (store_data_in),
        .out_valid     (out_valid),
        .alu_result    (alu_result),
        .zero          (zero),
        .overflow      (overflow),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .mem_read_out  (mem_read_out),
        .mem_write_out (mem_write_out),
        .store_data_out(store_data_out),
        .ex_count      (ex_count)
    );

    always #5 clk = ~clk;

    // ALU semantics in plain arithmetic; overflow means the exact signed result leaves 32 bits.
    function automatic void model_alu(input logic [3:0] c, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] sh,
                                      output logic [31:0] r, output logic o);
        longint sa;
        longint sb;
        longint s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        r  = 0;
        o  = 0;
        case (c)
            4'b0010: begin s = sa + sb; r = s[31:0]; o = (s > MAXS) || (s < MINS); end
            4'b0110: begin s = sa - sb; r = s[31:0]; o = (s > MAXS) || (s < MINS); end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = ~(a | b);
            4'b1000: r = a ^ b;
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0100: r = b << sh;
            4'b0101: r = b >> sh;
            4'b1001: r = b >> a[4:0];
            4'b1010: r = 32'($signed(b) >>> sh);
            4'b1111: r = {b[15:0], 16'h0000};
            default: r = 0;
        endcase
    endfunction

    // Model of the EX/MEM register, updated on the same events as the design.
    always @(posedge clk or posedge reset) begin
        logic [31:0] r;
        logic        o;
        logic        lv;
        if (reset) begin
            m_valid = 0; m_zero = 0; m_ovf = 0; m_rw = 0; m_mr = 0; m_mw = 0;
            m_result = 0; m_sd = 0; m_count = 0; m_rd = 0;
        end else if (!stall) begin
            model_alu(alu_ctl, op_a, op_b, shamt, r, o);
            lv       = in_valid && !flush;
            m_result = r;
            m_zero   = (r == 0);
            m_ovf    = o;
            m_rd     = rd_in;
            m_sd     = store_data_in;
            m_valid  = lv;
            m_rw     = lv && reg_write_in && !o;
            m_mr     = lv && mem_read_in;
            m_mw     = lv && mem_write_in;
            if (lv) m_count = m_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("alu_result", alu_result, m_result);
        check("zero", 32'(zero), 32'(m_zero));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rd_out", 32'(rd_out), 32'(m_rd));
        check("reg_write_out", 32'(reg_write_out), 32'(m_rw));
        check("mem_read_out", 32'(mem_read_out), 32'(m_mr));
        check("mem_write_out", 32'(mem_write_out), 32'(m_mw));
        check("store_data_out", store_data_out, m_sd);
        check("ex_count", ex_count, m_count + count_adj);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_result"}, alu_result, 0);
        check({tag, "_ctl"}, {29'd0, reg_write_out, mem_read_out, mem_write_out}, 0);
        check({tag, "_flags"}, {30'd0, zero, overflow}, 0);
        check({tag, "_rd_sd"}, store_data_out | 32'(rd_out), 0);
        check({tag, "_count"}, ex_count, 0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw);
        in_valid = v; alu_ctl = c; op_a = a; op_b = b; shamt = sh; rd_in = rd;
        reg_write_in = rw; mem_read_in = mr; mem_write_in = mw; store_data_in = b ^ 32'h5A5A_0000;
    endtask

    initial begin
        logic [31:0] held_count;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Signed overflow traps the register write
        drive(1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 5'd3, 1, 0, 0);
        step();
        check("ovf_result", alu_result, 32'h8000_0000);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_rw", 32'(reg_write_out), 0);
        check("ovf_valid", 32'(out_valid), 1);

        drive(1, 4'b0110, 32'd5, 32'd5, 0, 5'd4, 1, 0, 0);
        step();
        check("sub_zero_res", alu_result, 0);
        check("sub_zero_flag", 32'(zero), 1);

        drive(1, 4'b0111, 32'hFFFF_FFFF, 32'd1, 0, 5'd5, 1, 0, 0);
        step();
        check("slt", alu_result, 32'd1);

        drive(1, 4'b1010, 32'd0, 32'h8000_0000, 5'd4, 5'd6, 1, 0, 0);
        step();
        check("sra", alu_result, 32'hF800_0000);

        drive(1, 4'b1001, 32'd3, 32'h80, 5'd9, 5'd7, 1, 0, 0);
        step();
        check("srlv", alu_result, 32'h10);

        drive(1, 4'b1111, 32'd0, 32'h1234, 0, 5'd8, 1, 1, 0);
        step();
        check("lui", alu_result, 32'h1234_0000);

        // Remaining codes, sub overflow and an undefined code, checked against the model
        drive(1, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 5'd9, 1, 0, 0);  step();
        drive(1, 4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 5'd10, 1, 0, 1); step();
        drive(1, 4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 5'd11, 1, 0, 0); step();
        drive(1, 4'b1000, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 5'd12, 1, 0, 0); step();
        drive(1, 4'b0100, 32'd0, 32'h8000_0001, 5'd31, 5'd13, 1, 0, 0);     step();
        check("sll31", alu_result, 32'h8000_0000);
        drive(1, 4'b0101, 32'd0, 32'h8000_0000, 5'd31, 5'd14, 1, 0, 0);     step();
        check("srl31", alu_result, 32'h1);
        drive(1, 4'b0110, 32'h8000_0000, 32'd1, 0, 5'd15, 1, 0, 0);         step();
        check("sub_ovf", 32'(overflow), 1);
        drive(1, 4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 0, 5'd16, 1, 1, 1); step();
        check("undef_code", alu_result, 0);

        // Stall holds everything for three cycles even with flush and new inputs
        drive(1, 4'b0010, 32'd2, 32'd3, 0, 5'd7, 1, 0, 0);
        step();
        held_count = ex_count;
        check("pre_stall_res", alu_result, 32'd5);
        stall = 1; flush = 1;
        drive(1, 4'b1000, 32'hFFFF_0000, 32'h00FF_00FF, 0, 5'd21, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_res", alu_result, 32'd5);
            check("stall_count", ex_count, held_count);
        end
        stall = 0; flush = 0;
        step();
        check("post_stall_res", alu_result, 32'hFF00_00FF);
        check("post_stall_count", ex_count, held_count + 1);

        // Flush squashes a valid store
        held_count = ex_count;
        flush = 1;
        drive(1, 4'b0010, 32'd1, 32'd1, 0, 5'd2, 1, 0, 1);
        step();
        check("flush_valid", 32'(out_valid), 0);
        check("flush_mw", 32'(mem_write_out), 0);
        check("flush_count", ex_count, held_count);
        flush = 0;

        // Invalid instruction leaves all control bits low
        drive(0, 4'b0001, 32'd1, 32'd2, 0, 5'd3, 1, 1, 1);
        step();
        check("inval_ctl", {29'd0, reg_write_out, mem_read_out, mem_write_out}, 0);

        // Asynchronous reset mid-stall, then a normal load
        drive(1, 4'b0001, 32'h1, 32'h10, 0, 5'd9, 1, 1, 0);
        step();
        stall = 1;
        step();
        #2 reset = 1;
        #1 check_all_zero("async_reset");
        #1 reset = 0;
        stall = 0;
        drive(1, 4'b0010, 32'd40, 32'd2, 0, 5'd1, 1, 0, 0);
        step();
        check("post_reset_res", alu_result, 32'd42);
        check("post_reset_count", ex_count, 32'd1);

        // Counter wraps from all-ones to zero
        dut.ex_count_q = 32'hFFFF_FFFF;
        count_adj = 32'hFFFF_FFFF - m_count;
        drive(1, 4'b0000, 32'hFF, 32'h0F, 0, 5'd2, 0, 0, 0);
        step();
        check("count_wrap", ex_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
